pc_sequencer: RTL and testbench

Instruction sequencer owning the program counter and the fetch/execute cycle of the ForthCPU core. It fetches an instruction word over a ready-handshake, holds it in the instruction register while the execute datapath runs, then commits the next PC using the PC_OFFSETX / PC_BASEX selects produced by the branch logic. It also handles maskable interrupt entry and a HALT state.

---
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter and fetch/execute sequencer for the ForthCPU
//               core. Fetches an instruction over a ready handshake, holds it
//               in IR while the execute datapath runs, commits the next PC
//               from the branch selects, and handles maskable interrupt entry
//               and a HALT state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RESET           clock; synchronous active-high reset
//   MEM_READY, INSTR_IN  instruction fetch handshake and data
//   EXEC_DONE            execute datapath finished current instruction
//   PC_OFFSETX, PC_BASEX branch selects (offset instead of INC, base reg
//                        instead of PC)
//   BASE_IN, OFFSET_IN   absolute base and two's-complement byte offset
//   HALT_REQ             halt after the current instruction
//   INT_REQ, INT_VECTOR  level interrupt request and entry address
//   IE_SETX, IE_CLRX     interrupt enable set / clear (clear wins)
//   PC_OUT, FETCH_REQ    fetch address and fetch-in-progress
//   IR_OUT               instruction register
//   EXEC_STARTX          pulse on first EXECUTE cycle
//   INT_ACK, RET_PC      interrupt entry pulse and saved return PC
//   IE, HALTED, STATE    interrupt enable, halt status, debug state code
// ============================================================================
module pc_sequencer #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             MEM_READY,
  input  logic [WIDTH-1:0] INSTR_IN,
  input  logic             EXEC_DONE,
  input  logic             PC_OFFSETX,
  input  logic             PC_BASEX,
  input  logic [WIDTH-1:0] BASE_IN,
  input  logic [WIDTH-1:0] OFFSET_IN,
  input  logic             HALT_REQ,
  input  logic             INT_REQ,
  input  logic [WIDTH-1:0] INT_VECTOR,
  input  logic             IE_SETX,
  input  logic             IE_CLRX,
  output logic [WIDTH-1:0] PC_OUT,
  output logic             FETCH_REQ,
  output logic [WIDTH-1:0] IR_OUT,
  output logic             EXEC_STARTX,
  output logic             INT_ACK,
  output logic [WIDTH-1:0] RET_PC,
  output logic             IE,
  output logic             HALTED,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_EXECUTE   = 3'd1,
    ST_INTERRUPT = 3'd2,
    ST_HALT      = 3'd3
  } state_t;

  localparam logic [WIDTH-1:0] C_INC = WIDTH'(INC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] ret_pc_q, ret_pc_d;
  logic             ie_q, ie_d;
  logic             exec_start_q, exec_start_d;

  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_incr;
  logic             w_int_take;

  assign w_base = PC_BASEX   ? BASE_IN   : pc_q;
  assign w_incr = PC_OFFSETX ? OFFSET_IN : C_INC;

  // Interrupt decisions always use the registered enable, so a set arriving
  // in the same cycle as the boundary does not take effect there.
  assign w_int_take = INT_REQ & ie_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ret_pc_d     = ret_pc_q;
    exec_start_d = 1'b0;

    ie_d = ie_q;
    if (IE_SETX) ie_d = 1'b1;
    if (IE_CLRX) ie_d = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (MEM_READY) begin
          ir_d         = INSTR_IN;
          exec_start_d = 1'b1;
          state_d      = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (EXEC_DONE) begin
          pc_d = w_base + w_incr;
          if (w_int_take)    state_d = ST_INTERRUPT;
          else if (HALT_REQ) state_d = ST_HALT;
          else               state_d = ST_FETCH;
        end
      end
      ST_INTERRUPT: begin
        // pc_q already holds the committed next PC, which is the return point.
        ret_pc_d = pc_q;
        pc_d     = INT_VECTOR;
        ie_d     = 1'b0;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        if (w_int_take) state_d = ST_INTERRUPT;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_VECTOR;
      ir_q         <= '0;
      ret_pc_q     <= '0;
      ie_q         <= 1'b0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ret_pc_q     <= ret_pc_d;
      ie_q         <= ie_d;
      exec_start_q <= exec_start_d;
    end
  end

  // Status outputs decode registered state; they are forced low while reset
  // is held so nothing appears active before the first post-reset cycle.
  assign PC_OUT      = pc_q;
  assign IR_OUT      = ir_q;
  assign RET_PC      = ret_pc_q;
  assign IE          = ie_q;
  assign STATE       = state_q;
  assign FETCH_REQ   = ~RESET & (state_q == ST_FETCH);
  assign EXEC_STARTX = ~RESET & exec_start_q;
  assign INT_ACK     = ~RESET & (state_q == ST_INTERRUPT);
  assign HALTED      = ~RESET & (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. Inputs change
//               1 time unit after the rising edge; outputs are checked there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int WIDTH = 16;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             MEM_READY;
  logic [WIDTH-1:0] INSTR_IN;
  logic             EXEC_DONE;
  logic             PC_OFFSETX;
  logic             PC_BASEX;
  logic [WIDTH-1:0] BASE_IN;
  logic [WIDTH-1:0] OFFSET_IN;
  logic             HALT_REQ;
  logic             INT_REQ;
  logic [WIDTH-1:0] INT_VECTOR;
  logic             IE_SETX;
  logic             IE_CLRX;
  logic [WIDTH-1:0] PC_OUT;
  logic             FETCH_REQ;
  logic [WIDTH-1:0] IR_OUT;
  logic             EXEC_STARTX;
  logic             INT_ACK;
  logic [WIDTH-1:0] RET_PC;
  logic             IE;
  logic             HALTED;
  logic [2:0]       STATE;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (16'h0000),
    .INC          (2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .MEM_READY   (MEM_READY),
    .INSTR_IN    (INSTR_IN),
    .EXEC_DONE   (EXEC_DONE),
    .PC_OFFSETX  (PC_OFFSETX),
    .PC_BASEX    (PC_BASEX),
    .BASE_IN     (BASE_IN),
    .OFFSET_IN   (OFFSET_IN),
    .HALT_REQ    (HALT_REQ),
    .INT_REQ     (INT_REQ),
    .INT_VECTOR  (INT_VECTOR),
    .IE_SETX     (IE_SETX),
    .IE_CLRX     (IE_CLRX),
    .PC_OUT      (PC_OUT),
    .FETCH_REQ   (FETCH_REQ),
    .IR_OUT      (IR_OUT),
    .EXEC_STARTX (EXEC_STARTX),
    .INT_ACK     (INT_ACK),
    .RET_PC      (RET_PC),
    .IE          (IE),
    .HALTED      (HALTED),
    .STATE       (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete instruction: fetch with MEM_READY=1, then execute with
  // EXEC_DONE=1 and the given branch selects.
  task automatic run_instr(input logic bx, input logic ox,
                           input logic [WIDTH-1:0] base, input logic [WIDTH-1:0] off);
    MEM_READY = 1'b1;
    tick();
    MEM_READY  = 1'b0;
    EXEC_DONE  = 1'b1;
    PC_BASEX   = bx;
    PC_OFFSETX = ox;
    BASE_IN    = base;
    OFFSET_IN  = off;
    tick();
    EXEC_DONE  = 1'b0;
    PC_BASEX   = 1'b0;
    PC_OFFSETX = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; MEM_READY = 1'b0; INSTR_IN = '0; EXEC_DONE = 1'b0;
    PC_OFFSETX = 1'b0; PC_BASEX = 1'b0; BASE_IN = '0; OFFSET_IN = '0;
    HALT_REQ = 1'b0; INT_REQ = 1'b0; INT_VECTOR = '0; IE_SETX = 1'b0; IE_CLRX = 1'b0;

    // ---------------- reset state
    tick(); tick();
    check_eq("rst_pc",        PC_OUT,      16'h0000);
    check_eq("rst_ir",        IR_OUT,      16'h0000);
    check_eq("rst_retpc",     RET_PC,      16'h0000);
    check_eq("rst_ie",        IE,          1'b0);
    check_eq("rst_fetchreq",  FETCH_REQ,   1'b0);
    check_eq("rst_execstart", EXEC_STARTX, 1'b0);
    check_eq("rst_intack",    INT_ACK,     1'b0);
    check_eq("rst_halted",    HALTED,      1'b0);
    RESET = 1'b0;
    #1;
    check_eq("rel_fetchreq", FETCH_REQ, 1'b1);

    // ---------------- sequential fetch, one instruction per 2 cycles
    MEM_READY = 1'b1; EXEC_DONE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      INSTR_IN = 16'hC000 + 16'(k);
      check_eq("seq_pc_f",     PC_OUT,      32'(2 * k));
      check_eq("seq_fetchreq", FETCH_REQ,   1'b1);
      check_eq("seq_start_f",  EXEC_STARTX, 1'b0);
      tick();
      check_eq("seq_start_e",  EXEC_STARTX, 1'b1);
      check_eq("seq_pc_e",     PC_OUT,      32'(2 * k));
      check_eq("seq_ir",       IR_OUT,      32'(16'hC000 + 16'(k)));
      tick();
    end
    check_eq("seq_pc_end", PC_OUT, 16'h0008);

    // ---------------- wait states
    MEM_READY = 1'b0; EXEC_DONE = 1'b0; INSTR_IN = 16'hA5A5;
    for (int k = 0; k < 3; k++) begin
      check_eq("ws_fetchreq", FETCH_REQ, 1'b1);
      check_eq("ws_pc",       PC_OUT,    16'h0008);
      tick();
    end
    check_eq("ws_fetchreq4", FETCH_REQ, 1'b1);
    check_eq("ws_ir_old",    IR_OUT,    16'hC003);
    MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    check_eq("ws_ir",     IR_OUT,      16'hA5A5);
    check_eq("ws_start1", EXEC_STARTX, 1'b1);
    check_eq("ws_state1", STATE,       3'd1);
    tick();
    check_eq("ws_start2", EXEC_STARTX, 1'b0);
    check_eq("ws_state2", STATE,       3'd1);
    check_eq("ws_pc_ex",  PC_OUT,      16'h0008);
    tick();
    check_eq("ws_state3", STATE, 3'd1);
    EXEC_DONE = 1'b1;
    tick();
    EXEC_DONE = 1'b0;
    check_eq("ws_state_done", STATE,  3'd0);
    check_eq("ws_pc_next",    PC_OUT, 16'h000A);

    // ---------------- branches
    run_instr(1'b1, 1'b1, 16'h0010, 16'h0000);
    check_eq("br_abs10", PC_OUT, 16'h0010);
    run_instr(1'b0, 1'b1, 16'h0000, 16'hFFF8);
    check_eq("br_back",  PC_OUT, 16'h0008);
    run_instr(1'b1, 1'b1, 16'h1234, 16'h0000);
    check_eq("br_abs",   PC_OUT, 16'h1234);
    run_instr(1'b1, 1'b0, 16'hFFFC, 16'h7777);
    check_eq("br_base_inc", PC_OUT, 16'hFFFE);
    run_instr(1'b0, 1'b0, 16'h5555, 16'h7777);
    check_eq("br_wrap",  PC_OUT, 16'h0000);

    // ---------------- interrupt request with IE=0: ignored
    run_instr(1'b1, 1'b1, 16'h0040, 16'h0000);
    INT_REQ = 1'b1; INT_VECTOR = 16'h0100;
    run_instr(1'b0, 1'b0, 16'h0000, 16'h0000);
    INT_REQ = 1'b0;
    check_eq("noie_intack", INT_ACK, 1'b0);
    check_eq("noie_state",  STATE,   3'd0);
    check_eq("noie_pc",     PC_OUT,  16'h0042);

    // ---------------- interrupt entry with IE=1
    run_instr(1'b1, 1'b1, 16'h0040, 16'h0000);
    IE_SETX = 1'b1; MEM_READY = 1'b1;
    tick();
    IE_SETX = 1'b0; MEM_READY = 1'b0;
    check_eq("int_ie_set", IE, 1'b1);
    INT_REQ = 1'b1; EXEC_DONE = 1'b1;
    tick();
    INT_REQ = 1'b0; EXEC_DONE = 1'b0;
    check_eq("int_ack",     INT_ACK,   1'b1);
    check_eq("int_state",   STATE,     3'd2);
    check_eq("int_pc_next", PC_OUT,    16'h0042);
    check_eq("int_fetchrq", FETCH_REQ, 1'b0);
    tick();
    check_eq("int_ack_off", INT_ACK,   1'b0);
    check_eq("int_retpc",   RET_PC,    16'h0042);
    check_eq("int_ie_clr",  IE,        1'b0);
    check_eq("int_vec_pc",  PC_OUT,    16'h0100);
    check_eq("int_fetch",   FETCH_REQ, 1'b1);

    // IE_SETX in the EXEC_DONE cycle does not enable that boundary
    MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    EXEC_DONE = 1'b1; INT_REQ = 1'b1; IE_SETX = 1'b1;
    tick();
    EXEC_DONE = 1'b0; IE_SETX = 1'b0;
    check_eq("late_ie_state", STATE,   3'd0);
    check_eq("late_ie_ack",   INT_ACK, 1'b0);
    check_eq("late_ie_val",   IE,      1'b1);
    check_eq("late_ie_pc",    PC_OUT,  16'h0102);
    // INT_REQ held during FETCH is not sampled
    tick();
    check_eq("int_fetch_ignored", STATE, 3'd0);
    INT_REQ = 1'b0;
    // clear wins over set
    IE_SETX = 1'b1; IE_CLRX = 1'b1;
    tick();
    IE_SETX = 1'b0; IE_CLRX = 1'b0;
    check_eq("ie_clr_wins", IE, 1'b0);

    // ---------------- halt
    HALT_REQ = 1'b1;
    run_instr(1'b0, 1'b0, 16'h0000, 16'h0000);
    HALT_REQ = 1'b0;
    check_eq("halt_halted", HALTED,    1'b1);
    check_eq("halt_fetch",  FETCH_REQ, 1'b0);
    check_eq("halt_state",  STATE,     3'd3);
    MEM_READY = 1'b1; EXEC_DONE = 1'b1; PC_OFFSETX = 1'b1; OFFSET_IN = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("halt_pc_frozen", PC_OUT, 16'h0104);
      check_eq("halt_held",      HALTED, 1'b1);
    end
    MEM_READY = 1'b0; EXEC_DONE = 1'b0; PC_OFFSETX = 1'b0;
    IE_SETX = 1'b1;
    tick();
    IE_SETX = 1'b0;
    check_eq("halt_ie_on", IE,     1'b1);
    check_eq("halt_still", HALTED, 1'b1);
    INT_REQ = 1'b1; INT_VECTOR = 16'h0200;
    tick();
    INT_REQ = 1'b0;
    check_eq("halt_int_ack", INT_ACK, 1'b1);
    check_eq("halt_int_hlt", HALTED,  1'b0);
    tick();
    check_eq("halt_int_pc",    PC_OUT,    16'h0200);
    check_eq("halt_int_retpc", RET_PC,    16'h0104);
    check_eq("halt_int_fetch", FETCH_REQ, 1'b1);

    // ---------------- reset during a FETCH wait state
    IE_SETX = 1'b1;
    tick();
    IE_SETX = 1'b0;
    RESET = 1'b1;
    tick();
    check_eq("mrf_pc",    PC_OUT,    16'h0000);
    check_eq("mrf_ie",    IE,        1'b0);
    check_eq("mrf_ir",    IR_OUT,    16'h0000);
    check_eq("mrf_retpc", RET_PC,    16'h0000);
    check_eq("mrf_fetch", FETCH_REQ, 1'b0);
    RESET = 1'b0;
    #1;
    check_eq("mrf_fetch_rel", FETCH_REQ, 1'b1);

    // ---------------- reset during a multi-cycle EXECUTE
    run_instr(1'b1, 1'b1, 16'h3000, 16'h0000);
    IE_SETX = 1'b1; MEM_READY = 1'b1; INSTR_IN = 16'h5555;
    tick();
    IE_SETX = 1'b0; MEM_READY = 1'b0;
    tick();
    check_eq("mre_state", STATE,  3'd1);
    check_eq("mre_ir",    IR_OUT, 16'h5555);
    check_eq("mre_pc",    PC_OUT, 16'h3000);
    RESET = 1'b1; EXEC_DONE = 1'b1;
    tick();
    check_eq("mre_pc_rst", PC_OUT,  16'h0000);
    check_eq("mre_ir_rst", IR_OUT,  16'h0000);
    check_eq("mre_ie_rst", IE,      1'b0);
    check_eq("mre_state0", STATE,   3'd0);
    RESET = 1'b0; EXEC_DONE = 1'b0;
    MEM_READY = 1'b1; INSTR_IN = 16'h1111;
    tick();
    MEM_READY = 1'b0;
    check_eq("mre_restart_start", EXEC_STARTX, 1'b1);
    check_eq("mre_restart_ir",    IR_OUT,      16'h1111);
    EXEC_DONE = 1'b1;
    tick();
    EXEC_DONE = 1'b0;
    check_eq("mre_restart_pc", PC_OUT, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
